// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, default datapath width and the
// EX/MEM sideband payload. Imported by ALU control and the execute stage.
package alu_pkg;

  localparam int unsigned ALU_XLEN_DEFAULT = 32;
  localparam int unsigned ALU_CODE_W       = 4;
  localparam int unsigned REG_IDX_W        = 5;

  // Base operations
  localparam logic [ALU_CODE_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CODE_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB = 4'b0011;

  // Extended operations, only decoded when ALU_EXT_OPS_EN is defined
  localparam logic [ALU_CODE_W-1:0] ALU_XOR = 4'b0100;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT = 4'b0101;
  localparam logic [ALU_CODE_W-1:0] ALU_SLL = 4'b0110;
  localparam logic [ALU_CODE_W-1:0] ALU_SRL = 4'b0111;

  // Fixed-width part of an EX/MEM entry (result and store data travel beside it)
  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 zero;
    logic                 branch_taken;
    logic                 bad_code;
  } ex_meta_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU. Defining ALU_EXT_OPS_EN adds XOR/SLT/SLL/SRL; otherwise
// those codes decode as undefined (result 0, bad_code 1).
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = ALU_XLEN_DEFAULT
) (
  input  logic [ALU_CODE_W-1:0] alu_code,
  input  logic [XLEN-1:0]       op_a,
  input  logic [XLEN-1:0]       op_b,
  output logic [XLEN-1:0]       result,
  output logic                  zero,
  output logic                  bad_code
);

  always_comb begin
    result   = '0;
    bad_code = 1'b0;
    case (alu_code)
      ALU_AND: result = op_a & op_b;
      ALU_OR:  result = op_a | op_b;
      ALU_ADD: result = op_a + op_b;
      ALU_SUB: result = op_a - op_b;
`ifdef ALU_EXT_OPS_EN
      ALU_XOR: result = op_a ^ op_b;
      ALU_SLT: result = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLL: result = op_a << op_b[4:0];
      ALU_SRL: result = op_a >> op_b[4:0];
`endif
      default: bad_code = 1'b1;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: ALU plus registered EX/MEM output with a two-entry skid buffer
// so in_ready never depends combinationally on out_ready. ALU_EXT_OPS_EN (see alu_core).
module ex_alu_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = ALU_XLEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_CODE_W-1:0] alu_code,
  input  logic [XLEN-1:0]       op_a,
  input  logic [XLEN-1:0]       op_b,
  input  logic [XLEN-1:0]       store_data,
  input  logic [REG_IDX_W-1:0]  rd,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  branch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_result,
  output logic                  out_zero,
  output logic                  out_branch_taken,
  output logic                  out_bad_code,
  output logic [XLEN-1:0]       out_store_data,
  output logic [REG_IDX_W-1:0]  out_rd,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write
);

  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic            alu_bad;

  alu_core #(.XLEN(XLEN)) u_alu (
    .alu_code (alu_code),
    .op_a     (op_a),
    .op_b     (op_b),
    .result   (alu_result),
    .zero     (alu_zero),
    .bad_code (alu_bad)
  );

  ex_meta_t in_meta;

  always_comb begin
    in_meta              = '0;
    in_meta.rd           = rd;
    in_meta.reg_write    = reg_write;
    in_meta.mem_read     = mem_read;
    in_meta.mem_write    = mem_write;
    in_meta.zero         = alu_zero;
    in_meta.branch_taken = branch & alu_zero;
    in_meta.bad_code     = alu_bad;
  end

  logic            main_valid;
  logic [XLEN-1:0] main_result;
  logic [XLEN-1:0] main_store;
  ex_meta_t        main_meta;
  logic            skid_valid;
  logic [XLEN-1:0] skid_result;
  logic [XLEN-1:0] skid_store;
  ex_meta_t        skid_meta;
  logic            ready_q;

  logic accept_c;
  logic load_main_c;
  logic skid_valid_nxt_c;

  assign accept_c    = in_valid & ready_q;
  assign load_main_c = ~main_valid | out_ready;

  // Skid stays full only if it drains into main while a new input arrives,
  // or if main is blocked and an input lands in it.
  assign skid_valid_nxt_c = load_main_c ? (skid_valid & accept_c)
                                        : (skid_valid | accept_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid  <= 1'b0;
      main_result <= '0;
      main_store  <= '0;
      main_meta   <= '0;
      skid_valid  <= 1'b0;
      skid_result <= '0;
      skid_store  <= '0;
      skid_meta   <= '0;
      ready_q     <= 1'b1;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      skid_valid <= skid_valid_nxt_c;
      ready_q    <= ~skid_valid_nxt_c;
      if (load_main_c) begin
        main_valid <= skid_valid | accept_c;
        if (skid_valid) begin
          main_result <= skid_result;
          main_store  <= skid_store;
          main_meta   <= skid_meta;
        end else if (accept_c) begin
          main_result <= alu_result;
          main_store  <= store_data;
          main_meta   <= in_meta;
        end
      end
      if (accept_c && (skid_valid || !load_main_c)) begin
        skid_result <= alu_result;
        skid_store  <= store_data;
        skid_meta   <= in_meta;
      end
    end
  end

  assign in_ready         = ready_q;
  assign out_valid        = main_valid;
  assign out_result       = main_result;
  assign out_store_data   = main_store;
  assign out_zero         = main_meta.zero;
  assign out_branch_taken = main_meta.branch_taken;
  assign out_bad_code     = main_meta.bad_code;
  assign out_rd           = main_meta.rd;
  assign out_reg_write    = main_meta.reg_write;
  assign out_mem_read     = main_meta.mem_read;
  assign out_mem_write    = main_meta.mem_write;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Scoreboard bench for ex_alu_stage: expected entries are queued at accept and
// compared as MEM takes them; directed checks cover reset, stall, flush, reset.
module tb_ex_alu_stage;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        bt;
    logic        bad;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [3:0]  alu_code;
  logic [31:0] op_a, op_b, store_data;
  logic [4:0]  rd;
  logic        reg_write, mem_read, mem_write, branch;
  logic        out_valid, out_ready;
  logic [31:0] out_result, out_store_data;
  logic        out_zero, out_branch_taken, out_bad_code;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_mem_read, out_mem_write;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic        sends_done;

  always #5 clk = ~clk;

  ex_alu_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_code(alu_code), .op_a(op_a), .op_b(op_b), .store_data(store_data),
    .rd(rd), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_branch_taken(out_branch_taken), .out_bad_code(out_bad_code),
    .out_store_data(out_store_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] sd, input logic [4:0] r,
                                 input logic rw, input logic mr, input logic mw, input logic br);
    exp_t e;
    e.res = 32'h0;
    e.bad = 1'b0;
    if      (c == 4'd0) e.res = a & b;
    else if (c == 4'd1) e.res = a | b;
    else if (c == 4'd2) e.res = a + b;
    else if (c == 4'd3) e.res = a + ~b + 32'd1;
`ifdef ALU_EXT_OPS_EN
    else if (c == 4'd4) e.res = a ^ b;
    else if (c == 4'd5) e.res = {31'd0, (a[31] != b[31]) ? a[31] : (a < b)};
    else if (c == 4'd6) e.res = a << b[4:0];
    else if (c == 4'd7) e.res = a >> b[4:0];
`endif
    else e.bad = 1'b1;
    e.zero = (e.res == 32'h0);
    e.bt   = br & e.zero;
    e.sd   = sd;
    e.rd   = r;
    e.rw   = rw;
    e.mr   = mr;
    e.mw   = mw;
    return e;
  endfunction

  // MEM side: pop and compare each entry as it is taken
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("result",       64'(out_result),       64'(mon_e.res));
        chk("zero",         64'(out_zero),         64'(mon_e.zero));
        chk("branch_taken", 64'(out_branch_taken), 64'(mon_e.bt));
        chk("bad_code",     64'(out_bad_code),     64'(mon_e.bad));
        chk("store_data",   64'(out_store_data),   64'(mon_e.sd));
        chk("rd",           64'(out_rd),           64'(mon_e.rd));
        chk("ctrl",         64'({out_reg_write, out_mem_read, out_mem_write}),
                            64'({mon_e.rw, mon_e.mr, mon_e.mw}));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic br);
    int unsigned w;
    alu_code   = c;
    op_a       = a;
    op_b       = b;
    branch     = br;
    store_data = $urandom;
    rd         = 5'($urandom);
    reg_write  = 1'($urandom);
    mem_read   = 1'($urandom);
    mem_write  = 1'($urandom);
    in_valid   = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    else sb.push_back(model(c, a, b, store_data, rd, reg_write, mem_read, mem_write, br));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_code = 4'd0; op_a = 32'd0; op_b = 32'd0; store_data = 32'd0;
    rd = 5'd0; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; branch = 1'b0;
    sends_done = 1'b0;
    tick(3);
    @(negedge clk);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_payload",   64'(out_result | out_store_data), 64'd0);
    chk("rst_flags",     64'({out_zero, out_branch_taken, out_bad_code, out_rd,
                              out_reg_write, out_mem_read, out_mem_write}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(2);
    @(negedge clk);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Streaming
    out_ready = 1'b1;
    send(ALU_ADD, 32'd5, 32'd7, 1'b0);
    send(ALU_SUB, 32'd3, 32'd3, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_2nd_valid", 64'(out_valid), 64'd1);
    chk("stream_2nd_bt",    64'(out_branch_taken), 64'd1);
    tick(2);

    // Back-pressure: main then skid fill
    out_ready = 1'b0;
    send(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 1'b0);
    send(ALU_OR,  32'h1, 32'h2, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("stall_in_ready", 64'(in_ready),   64'd0);
    chk("stall_result",   64'(out_result), 64'h0000_F000);
    tick(3);
    @(negedge clk);
    chk("stall_held",     64'(out_result), 64'h0000_F000);
    chk("stall_valid",    64'(out_valid),  64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready_0", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_in_ready_1", 64'(in_ready), 64'd1);
    tick(2);
    chk("bp_drained", 64'(sb.size()), 64'd0);

    // Flush with both registers full and a new input in the same cycle
    out_ready = 1'b0;
    send(ALU_AND, 32'h1, 32'h1, 1'b0);
    send(ALU_ADD, 32'h2, 32'h2, 1'b0);
    alu_code = ALU_ADD; op_a = 32'hDEAD; op_b = 32'h0; in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    tick(3);
    @(negedge clk);
    chk("flush_no_ghost", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Boundary codes
    send(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 1'b0);
    send(ALU_SUB, 32'h0, 32'h1, 1'b1);
    send(4'hF, 32'h9, 32'h9, 1'b1);
    send(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1);
    send(ALU_SLL, 32'h8000_0001, 32'h21, 1'b0);
    send(ALU_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000, 1'b0);
    in_valid = 1'b0;
    tick(3);

    // Random codes with random MEM back-pressure
    fork
      begin
        for (int i = 0; i < 40; i++)
          send(4'($urandom), $urandom, (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom,
               1'($urandom));
        in_valid = 1'b0;
        sends_done = 1'b1;
      end
      begin
        while (!sends_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom);
        end
      end
    join
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
    chk("random_drained", 64'(sb.size()), 64'd0);

    // Reset mid-transfer
    out_ready = 1'b0;
    send(ALU_OR, 32'h10, 32'h20, 1'b0);
    send(ALU_OR, 32'h30, 32'h40, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid),  64'd0);
    chk("midrst_in_ready",  64'(in_ready),   64'd1);
    chk("midrst_result",    64'(out_result), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    tick(3);
    @(negedge clk);
    chk("midrst_no_ghost", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
